axi_lite_master_bridge: RTL and testbench

Converts the native PicoRV32-style memory request port (`mem_valid`/`mem_ready`) into AXI4-Lite master transactions toward the system memory and peripherals. It is the initiator end of the `mem_axi_*` interface served by the testbench memory model and the SoC interconnect. The bridge uses registered outputs and runs one transaction at a time. Posted writes are optional, and the bridge reports per-transaction latency for profiling.

---
 rtl/axi_lite_master_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_lite_master_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_bridge.sv
// Bridges a PicoRV32-style mem_valid/mem_ready request port onto an AXI4-Lite master,
// one transaction at a time, with optional posted writes and a per-transaction latency counter.
module axi_lite_master_bridge #(
  parameter bit POSTED_WRITES = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  // Native core port
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  // AW channel
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  // W channel
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  // B channel
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  // AR channel
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  // R channel
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  // Profiling
  output logic [15:0] last_latency
);

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRdata,
    StWreq,
    StWresp,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        pend_b_q, pend_b_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        rready_q, rready_d;
  logic        bready_q, bready_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] lat_q, lat_d;
  logic [15:0] last_lat_q, last_lat_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;

  logic        b_hs;
  logic        aw_ok;
  logic        w_ok;
  logic [15:0] lat_inc;

  always_comb begin
    state_d     = state_q;
    pend_b_d    = pend_b_q;
    arvalid_d   = arvalid_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    mem_ready_d = 1'b0;
    rdata_d     = rdata_q;
    lat_d       = lat_q;
    last_lat_d  = last_lat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    instr_d     = instr_q;

    b_hs    = mem_axi_bvalid && bready_q;
    lat_inc = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
    // A finished handshake leaves the valid low, so "low" also means "done".
    aw_ok   = !awvalid_q || mem_axi_awready;
    w_ok    = !wvalid_q || mem_axi_wready;

    if (pend_b_q && b_hs) begin
      pend_b_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (mem_valid && !pend_b_q) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          lat_d   = 16'd0;
          if (|mem_wstrb) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWreq;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRaddr;
          end
        end
      end
      StRaddr: begin
        lat_d = lat_inc;
        if (arvalid_q && mem_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        lat_d = lat_inc;
        if (mem_axi_rvalid && rready_q) begin
          rdata_d = mem_axi_rdata;
          state_d = StDone;
        end
      end
      StWreq: begin
        lat_d = lat_inc;
        if (awvalid_q && mem_axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && mem_axi_wready) begin
          wvalid_d = 1'b0;
        end
        if (aw_ok && w_ok) begin
          if (POSTED_WRITES) begin
            pend_b_d = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StWresp;
          end
        end
      end
      StWresp: begin
        lat_d = lat_inc;
        if (b_hs) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    rready_d = (state_d == StRdata);
    bready_d = (state_d == StWresp) || pend_b_d;

    if (state_d == StDone && state_q != StDone) begin
      mem_ready_d = 1'b1;
      last_lat_d  = lat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_b_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      rdata_q     <= 32'd0;
      lat_q       <= 16'd0;
      last_lat_q  <= 16'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      instr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_b_q    <= pend_b_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
      mem_ready_q <= mem_ready_d;
      rdata_q     <= rdata_d;
      lat_q       <= lat_d;
      last_lat_q  <= last_lat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      instr_q     <= instr_d;
    end
  end

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = rdata_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = {instr_q, 2'b00};
  assign mem_axi_rready  = rready_q;
  assign last_latency    = last_lat_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench: instance 0 uses non-posted writes, instance 1 posted writes; each has a
// small AXI-Lite slave with programmable per-channel delays.
module tb_axi_lite_master_bridge;

  logic clk;
  logic reset;

  logic [1:0]       mem_valid;
  logic [1:0]       mem_instr;
  logic [1:0][31:0] mem_addr;
  logic [1:0][31:0] mem_wdata;
  logic [1:0][3:0]  mem_wstrb;
  logic [1:0]       mem_ready;
  logic [1:0][31:0] mem_rdata;
  logic [1:0][15:0] last_latency;

  int aw_dly [2];
  int w_dly  [2];
  int b_dly  [2];
  int ar_dly [2];
  int r_dly  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;

    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          b_hs, rdy_cnt, bready_bad, ar_in_b;
    logic        aw_done, w_done, r_pend, b_pend;
    logic [3:0]  r_idx;
    logic [31:0] mem [16];

    assign b_pend  = aw_done && w_done;
    assign awready = awvalid && (aw_cnt >= aw_dly[g]);
    assign wready  = wvalid && (w_cnt >= w_dly[g]);
    assign bvalid  = b_pend && (b_cnt >= b_dly[g]);
    assign arready = arvalid && (ar_cnt >= ar_dly[g]);
    assign rvalid  = r_pend && (r_cnt >= r_dly[g]);
    assign rdata   = mem[r_idx];

    axi_lite_master_bridge #(
      .POSTED_WRITES(g == 1)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .mem_valid      (mem_valid[g]),
      .mem_instr      (mem_instr[g]),
      .mem_addr       (mem_addr[g]),
      .mem_wdata      (mem_wdata[g]),
      .mem_wstrb      (mem_wstrb[g]),
      .mem_ready      (mem_ready[g]),
      .mem_rdata      (mem_rdata[g]),
      .mem_axi_awvalid(awvalid),
      .mem_axi_awready(awready),
      .mem_axi_awaddr (awaddr),
      .mem_axi_awprot (awprot),
      .mem_axi_wvalid (wvalid),
      .mem_axi_wready (wready),
      .mem_axi_wdata  (wdata),
      .mem_axi_wstrb  (wstrb),
      .mem_axi_bvalid (bvalid),
      .mem_axi_bready (bready),
      .mem_axi_arvalid(arvalid),
      .mem_axi_arready(arready),
      .mem_axi_araddr (araddr),
      .mem_axi_arprot (arprot),
      .mem_axi_rvalid (rvalid),
      .mem_axi_rready (rready),
      .mem_axi_rdata  (rdata),
      .last_latency   (last_latency[g])
    );

    always_ff @(posedge clk) begin
      if (mem_ready[g]) rdy_cnt <= rdy_cnt + 1;
      if (bready && !b_pend) bready_bad <= bready_bad + 1;
      if (arvalid && b_pend) ar_in_b <= ar_in_b + 1;
      if (reset) begin
        aw_cnt  <= 0;
        w_cnt   <= 0;
        b_cnt   <= 0;
        ar_cnt  <= 0;
        r_cnt   <= 0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        r_pend  <= 1'b0;
        r_idx   <= 4'd0;
        for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'h1234_5678 : 32'd0;
      end else begin
        if (b_pend) begin
          if (bvalid && bready) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            b_cnt   <= 0;
            b_hs    <= b_hs + 1;
          end else begin
            b_cnt <= b_cnt + 1;
          end
        end
        if (awvalid && awready) begin
          aw_done <= 1'b1;
          aw_cnt  <= 0;
        end else if (awvalid) begin
          aw_cnt <= aw_cnt + 1;
        end
        if (wvalid && wready) begin
          w_done <= 1'b1;
          w_cnt  <= 0;
          for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[awaddr[5:2]][8*i +: 8] <= wdata[8*i +: 8];
          end
        end else if (wvalid) begin
          w_cnt <= w_cnt + 1;
        end
        if (arvalid && arready) begin
          r_pend <= 1'b1;
          r_idx  <= araddr[5:2];
          ar_cnt <= 0;
        end else if (arvalid) begin
          ar_cnt <= ar_cnt + 1;
        end
        if (rvalid && rready) begin
          r_pend <= 1'b0;
          r_cnt  <= 0;
        end else if (r_pend) begin
          r_cnt <= r_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int k, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb);
    mem_instr[k] = instr;
    mem_addr[k]  = addr;
    mem_wdata[k] = wd;
    mem_wstrb[k] = strb;
    mem_valid[k] = 1'b1;
  endtask

  task automatic wait_ready(input int k, input int maxcyc);
    bit seen = 1'b0;
    int cyc  = 0;
    while (!seen && cyc < maxcyc) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = mem_ready[k];
    end
    mem_valid[k] = 1'b0;
    chk("ready_seen", 64'(seen), 64'd1);
  endtask

  int r0;
  int b0;

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    mem_valid = '0;
    mem_instr = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    for (int i = 0; i < 2; i++) begin
      aw_dly[i] = 0;
      w_dly[i]  = 0;
      b_dly[i]  = 0;
      ar_dly[i] = 0;
      r_dly[i]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ready", 64'(mem_ready[0]), 64'd0);
    chk("rst_last_lat", 64'(last_latency[0]), 64'd0);
    chk("rst_arvalid", 64'(g_dut[0].arvalid), 64'd0);
    chk("rst_rdata", 64'(mem_rdata[0]), 64'd0);
    reset = 1'b0;

    // Zero-wait instruction read
    issue(0, 1'b1, 32'h100, 32'd0, 4'd0);
    @(posedge clk);
    #1;
    chk("rd_arvalid", 64'(g_dut[0].arvalid), 64'd1);
    chk("rd_arprot", 64'(g_dut[0].arprot), 64'h4);
    r0 = g_dut[0].rdy_cnt;
    wait_ready(0, 20);
    chk("rd_data", 64'(mem_rdata[0]), 64'h1234_5678);
    chk("rd_latency", 64'(last_latency[0]), 64'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_one_pulse", 64'(g_dut[0].rdy_cnt - r0), 64'd1);
    chk("rd_rdata_hold", 64'(mem_rdata[0]), 64'h1234_5678);

    // Write with W accepted three cycles before AW
    aw_dly[0] = 3;
    b0 = g_dut[0].b_hs;
    issue(0, 1'b0, 32'h104, 32'hAABB_CCDD, 4'b0110);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("w_first_wvalid", 64'(g_dut[0].wvalid), 64'd0);
    chk("w_first_awvalid", 64'(g_dut[0].awvalid), 64'd1);
    chk("w_awprot", 64'(g_dut[0].awprot), 64'd0);
    wait_ready(0, 20);
    chk("w_first_latency", 64'(last_latency[0]), 64'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("w_first_b_count", 64'(g_dut[0].b_hs - b0), 64'd1);
    chk("w_first_mem", 64'(g_dut[0].mem[1]), 64'h00BB_CC00);
    aw_dly[0] = 0;

    // Same-edge AW/W, B delayed 5 cycles
    b_dly[0] = 5;
    b0 = g_dut[0].b_hs;
    issue(0, 1'b0, 32'h108, 32'h1122_3344, 4'hF);
    wait_ready(0, 30);
    chk("wb_latency", 64'(last_latency[0]), 64'd7);
    chk("wb_bready_only_wresp", 64'(g_dut[0].bready_bad), 64'd0);
    chk("wb_b_count", 64'(g_dut[0].b_hs - b0), 64'd1);
    chk("wb_mem", 64'(g_dut[0].mem[2]), 64'h1122_3344);
    b_dly[0] = 0;

    // Posted write followed at once by a read, B delayed 10 cycles
    b_dly[1] = 10;
    b0 = g_dut[1].b_hs;
    issue(1, 1'b0, 32'h10C, 32'hCAFE_F00D, 4'hF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pw_ready", 64'(mem_ready[1]), 64'd1);
    chk("pw_awvalid", 64'(g_dut[1].awvalid), 64'd0);
    chk("pw_wvalid", 64'(g_dut[1].wvalid), 64'd0);
    chk("pw_awprot", 64'(g_dut[1].awprot), 64'd0);
    chk("pw_latency", 64'(last_latency[1]), 64'd1);
    chk("pw_bready", 64'(g_dut[1].bready), 64'd1);
    issue(1, 1'b0, 32'h100, 32'd0, 4'd0);
    wait_ready(1, 40);
    chk("pw_rd_data", 64'(mem_rdata[1]), 64'h1234_5678);
    chk("pw_rd_latency", 64'(last_latency[1]), 64'd2);
    chk("pw_ar_during_b", 64'(g_dut[1].ar_in_b), 64'd0);
    chk("pw_b_count", 64'(g_dut[1].b_hs - b0), 64'd1);
    chk("pw_mem", 64'(g_dut[1].mem[3]), 64'hCAFE_F00D);

    // Reset while waiting in RDATA
    r_dly[0] = 20;
    issue(0, 1'b0, 32'h100, 32'd0, 4'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_mid_rready_pre", 64'(g_dut[0].rready), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mem_valid[0] = 1'b0;
    reset = 1'b0;
    chk("rst_mid_arvalid", 64'(g_dut[0].arvalid), 64'd0);
    chk("rst_mid_awvalid", 64'(g_dut[0].awvalid), 64'd0);
    chk("rst_mid_wvalid", 64'(g_dut[0].wvalid), 64'd0);
    chk("rst_mid_rready", 64'(g_dut[0].rready), 64'd0);
    chk("rst_mid_bready", 64'(g_dut[0].bready), 64'd0);
    chk("rst_mid_mem_ready", 64'(mem_ready[0]), 64'd0);
    chk("rst_mid_last_lat", 64'(last_latency[0]), 64'd0);
    chk("rst_mid_rdata", 64'(mem_rdata[0]), 64'd0);
    r_dly[0] = 0;
    @(posedge clk);
    #1;
    issue(0, 1'b0, 32'h100, 32'd0, 4'd0);
    @(posedge clk);
    #1;
    chk("post_rst_arprot", 64'(g_dut[0].arprot), 64'd0);
    wait_ready(0, 20);
    chk("post_rst_data", 64'(mem_rdata[0]), 64'h1234_5678);
    chk("post_rst_latency", 64'(last_latency[0]), 64'd2);

    // Very slow R: latency saturates, data still returned
    r_dly[0] = 70000;
    issue(0, 1'b0, 32'h100, 32'd0, 4'd0);
    wait_ready(0, 80000);
    chk("sat_latency", 64'(last_latency[0]), 64'hFFFF);
    chk("sat_data", 64'(mem_rdata[0]), 64'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
